// File: rtl/jpeg_huffman_encoder.sv
// Bit-serial canonical Huffman encoder: 256-entry code/length table, MSB-first
// code bits followed by raw extra bits, with 1-fill byte-align padding on flush.
module jpeg_huffman_encoder #(
  parameter int CODE_W  = 16,
  parameter int LEN_W   = 5,
  parameter int EXTRA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               enable,
  input  logic               tbl_wr_en,
  input  logic [7:0]         tbl_wr_sym,
  input  logic [CODE_W-1:0]  tbl_wr_code,
  input  logic [LEN_W-1:0]   tbl_wr_len,
  input  logic [7:0]         sym_in,
  input  logic [EXTRA_W-1:0] extra_in,
  input  logic [4:0]         extra_len,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic               flush,
  output logic               bit_out,
  output logic               bit_valid,
  input  logic               bit_ready,
  output logic               flush_done,
  output logic               err_unmapped
);

  localparam int IDX_W = (LEN_W > 5) ? LEN_W : 5;
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] XMAX = IDX_W'(EXTRA_W);

  typedef enum logic [1:0] {IDLE, CODE, EXTRA, PAD} state_e;

  logic [LEN_W-1:0]  len_tbl_q  [256];
  logic [CODE_W-1:0] code_tbl_q [256];

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [EXTRA_W-1:0] extra_q, extra_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   xlen_q, xlen_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               bit_valid_q, bit_valid_d;
  logic               bit_out_q, bit_out_d;
  logic               flush_done_q, flush_done_d;
  logic               err_q, err_d;

  logic [LEN_W-1:0]  lk_len;
  logic [CODE_W-1:0] lk_code;
  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  xl_clamp;
  logic              hs, accept, flush_req;

  function automatic logic code_bit(input logic [CODE_W-1:0] v, input logic [IDX_W-1:0] i);
    logic [CODE_W-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic extra_bit(input logic [EXTRA_W-1:0] v, input logic [IDX_W-1:0] i);
    logic [EXTRA_W-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Lengths reset so every symbol reads as unmapped; codes need no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 256; i++) len_tbl_q[i] <= '0;
    end else if (tbl_wr_en) begin
      len_tbl_q[tbl_wr_sym] <= tbl_wr_len;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_wr_en) code_tbl_q[tbl_wr_sym] <= tbl_wr_code;
  end

  assign lk_len    = len_tbl_q[sym_in];
  assign lk_code   = code_tbl_q[sym_in];
  assign lk_idx    = IDX_W'(lk_len) - ONE;
  assign xl_clamp  = (IDX_W'(extra_len) > XMAX) ? XMAX : IDX_W'(extra_len);
  assign sym_ready = rst_n & (state_q == IDLE) & enable & ~flush_pend_q & ~start;
  assign hs        = bit_valid_q & bit_ready;
  assign accept    = sym_valid & sym_ready;
  assign flush_req = flush_pend_q | flush;

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    extra_d      = extra_q;
    idx_d        = idx_q;
    xlen_d       = xlen_q;
    bit_cnt_d    = hs ? bit_cnt_q + 3'd1 : bit_cnt_q;
    flush_pend_d = flush_req;
    bit_valid_d  = bit_valid_q;
    bit_out_d    = bit_out_q;
    flush_done_d = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (lk_len != '0) begin
            code_d      = lk_code;
            extra_d     = extra_in;
            xlen_d      = xl_clamp;
            idx_d       = lk_idx;
            bit_out_d   = code_bit(lk_code, lk_idx);
            bit_valid_d = 1'b1;
            state_d     = CODE;
          end else begin
            err_d = 1'b1;
          end
        end else if (flush_req) begin
          if (bit_cnt_q == '0) begin
            flush_done_d = 1'b1;
            flush_pend_d = 1'b0;
          end else begin
            state_d     = PAD;
            bit_valid_d = 1'b1;
            bit_out_d   = 1'b1;
          end
        end
      end
      CODE: begin
        if (hs) begin
          if (idx_q == '0) begin
            if (xlen_q != '0) begin
              state_d   = EXTRA;
              idx_d     = xlen_q - ONE;
              bit_out_d = extra_bit(extra_q, xlen_q - ONE);
            end else begin
              state_d     = IDLE;
              bit_valid_d = 1'b0;
            end
          end else begin
            idx_d     = idx_q - ONE;
            bit_out_d = code_bit(code_q, idx_q - ONE);
          end
        end
      end
      EXTRA: begin
        if (hs) begin
          if (idx_q == '0) begin
            state_d     = IDLE;
            bit_valid_d = 1'b0;
          end else begin
            idx_d     = idx_q - ONE;
            bit_out_d = extra_bit(extra_q, idx_q - ONE);
          end
        end
      end
      PAD: begin
        if (hs && bit_cnt_q == 3'd7) begin
          state_d      = IDLE;
          bit_valid_d  = 1'b0;
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d      = IDLE;
      bit_valid_d  = 1'b0;
      bit_cnt_d    = '0;
      flush_pend_d = 1'b0;
      flush_done_d = 1'b0;
      err_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      code_q       <= '0;
      extra_q      <= '0;
      idx_q        <= '0;
      xlen_q       <= '0;
      bit_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_out_q    <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      extra_q      <= extra_d;
      idx_q        <= idx_d;
      xlen_q       <= xlen_d;
      bit_cnt_q    <= bit_cnt_d;
      flush_pend_q <= flush_pend_d;
      bit_valid_q  <= bit_valid_d;
      bit_out_q    <= bit_out_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

  assign bit_out      = bit_out_q;
  assign bit_valid    = bit_valid_q;
  assign flush_done   = flush_done_q;
  assign err_unmapped = err_q;

endmodule

// File: tb/tb_jpeg_huffman_encoder.sv
// Directed bench for jpeg_huffman_encoder: table-driven symbol vectors plus
// hand sequences for flush, unmapped symbols, start and async reset.
module tb_jpeg_huffman_encoder;

  logic        clk = 1'b0;
  logic        rst_n, start, enable, tbl_wr_en;
  logic [7:0]  tbl_wr_sym, sym_in;
  logic [15:0] tbl_wr_code, extra_in;
  logic [4:0]  tbl_wr_len, extra_len;
  logic        sym_valid, sym_ready, flush, bit_out, bit_valid, bit_ready;
  logic        flush_done, err_unmapped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jpeg_huffman_encoder #(.CODE_W(16), .LEN_W(5), .EXTRA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_sym(tbl_wr_sym), .tbl_wr_code(tbl_wr_code),
    .tbl_wr_len(tbl_wr_len), .sym_in(sym_in), .extra_in(extra_in),
    .extra_len(extra_len), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .flush(flush), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .flush_done(flush_done), .err_unmapped(err_unmapped)
  );

  typedef struct {
    logic [7:0]  sym;
    logic [15:0] x;
    logic [4:0]  xl;
    bit          tog;
    logic [31:0] bits;
    int          n;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] s, input logic [15:0] c, input logic [4:0] l);
    tbl_wr_en = 1'b1; tbl_wr_sym = s; tbl_wr_code = c; tbl_wr_len = l;
    tick();
    tbl_wr_en = 1'b0;
  endtask

  // Offers one symbol, then collects handshaken bits until bit_valid drops.
  task automatic run_sym(input logic [7:0] s, input logic [15:0] x, input logic [4:0] xl,
                         input bit tog, input bit fl, output logic [31:0] bits,
                         output int n, output bit err1, output bit busy_rdy);
    bit prev_stall;
    logic prev_bit;
    bits = '0; n = 0; busy_rdy = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0;
    sym_in = s; extra_in = x; extra_len = xl; sym_valid = 1'b1; flush = fl; bit_ready = 1'b1;
    tick();
    sym_valid = 1'b0; flush = 1'b0;
    err1 = err_unmapped;
    for (int c = 0; c < 80; c++) begin
      if (!bit_valid) break;
      bit_ready = tog ? (c % 3 == 0) : 1'b1;
      if (sym_ready) busy_rdy = 1'b1;
      if (prev_stall) check("stall_hold", {31'b0, bit_out}, {31'b0, prev_bit});
      prev_stall = !bit_ready;
      prev_bit   = bit_out;
      if (bit_ready) begin
        bits = {bits[30:0], bit_out};
        n++;
      end
      tick();
    end
    bit_ready = 1'b1;
    check("sym_end_timeout", {31'b0, bit_valid}, 32'd0);
  endtask

  task automatic do_flush(input bit pulse, output int pads, output int wait_c, output bit ones);
    if (pulse) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    bit_ready = 1'b1; pads = 0; wait_c = -1; ones = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (flush_done) begin
        wait_c = c;
        break;
      end
      if (bit_valid) begin
        pads++;
        if (!bit_out) ones = 1'b0;
      end
      tick();
    end
  endtask

  logic [31:0] bits;
  int n, pads, wc;
  bit e1, br, ones;

  initial begin
    vecs[0] = '{8'h0A, 16'h0,    5'd0,  1'b0, 32'h0,     1};
    vecs[1] = '{8'h0B, 16'h0,    5'd0,  1'b0, 32'b10,    2};
    vecs[2] = '{8'h0C, 16'h0,    5'd0,  1'b0, 32'b110,   3};
    vecs[3] = '{8'h0A, 16'h0,    5'd0,  1'b1, 32'h0,     1};
    vecs[4] = '{8'h0B, 16'h0,    5'd0,  1'b1, 32'b10,    2};
    vecs[5] = '{8'h0C, 16'h0,    5'd0,  1'b1, 32'b110,   3};
    vecs[6] = '{8'h0B, 16'h5,    5'd3,  1'b0, 32'b10101, 5};
    vecs[7] = '{8'h0C, 16'hABCD, 5'd20, 1'b0, 32'h6ABCD, 19};
    vecs[8] = '{8'h0A, 16'h1,    5'd1,  1'b1, 32'b01,    2};
    vecs[9] = '{8'h0D, 16'h0,    5'd0,  1'b0, 32'hF00F,  16};

    rst_n = 1'b0; start = 1'b0; enable = 1'b1; tbl_wr_en = 1'b0;
    tbl_wr_sym = '0; tbl_wr_code = '0; tbl_wr_len = '0; sym_in = '0;
    extra_in = '0; extra_len = '0; sym_valid = 1'b0; flush = 1'b0; bit_ready = 1'b1;

    @(negedge clk);
    check("rst_bit_valid", {31'b0, bit_valid}, 32'd0);
    check("rst_bit_out", {31'b0, bit_out}, 32'd0);
    check("rst_flush_done", {31'b0, flush_done}, 32'd0);
    check("rst_err", {31'b0, err_unmapped}, 32'd0);
    check("rst_sym_ready", {31'b0, sym_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_sym_ready", {31'b0, sym_ready}, 32'd1);

    wr(8'h0A, 16'h0, 5'd1);
    wr(8'h0B, 16'h2, 5'd2);
    wr(8'h0C, 16'h6, 5'd3);
    wr(8'h0D, 16'hF00F, 5'd16);

    for (int i = 0; i < 10; i++) begin
      run_sym(vecs[i].sym, vecs[i].x, vecs[i].xl, vecs[i].tog, 1'b0, bits, n, e1, br);
      check($sformatf("vec%0d_bits", i), bits, vecs[i].bits);
      check($sformatf("vec%0d_count", i), n, vecs[i].n);
      check($sformatf("vec%0d_err", i), {31'b0, e1}, 32'd0);
      check($sformatf("vec%0d_busy_ready", i), {31'b0, br}, 32'd0);
      check($sformatf("vec%0d_bubble_ready", i), {31'b0, sym_ready}, 32'd1);
    end

    // 54 bits sent so far: 2 pad bits to the byte boundary
    do_flush(1'b1, pads, wc, ones);
    check("flush1_pads", pads, 2);
    check("flush1_wait", wc, 2);
    check("flush1_ones", {31'b0, ones}, 32'd1);
    do_flush(1'b1, pads, wc, ones);
    check("flush2_pads", pads, 0);
    check("flush2_wait", wc, 0);
    tick();
    check("flush_done_pulse", {31'b0, flush_done}, 32'd0);

    enable = 1'b0; sym_in = 8'h0A; sym_valid = 1'b1;
    #1 check("enable0_ready", {31'b0, sym_ready}, 32'd0);
    tick();
    check("enable0_no_bit", {31'b0, bit_valid}, 32'd0);
    sym_valid = 1'b0; enable = 1'b1;

    run_sym(8'h55, 16'h0, 5'd0, 1'b0, 1'b0, bits, n, e1, br);
    check("unmapped_err", {31'b0, e1}, 32'd1);
    check("unmapped_bits", n, 0);
    check("unmapped_ready", {31'b0, sym_ready}, 32'd1);
    tick();
    check("unmapped_err_pulse", {31'b0, err_unmapped}, 32'd0);

    tbl_wr_en = 1'b1; tbl_wr_sym = 8'h55; tbl_wr_code = 16'hE; tbl_wr_len = 5'd4;
    sym_in = 8'h55; sym_valid = 1'b1;
    tick();
    tbl_wr_en = 1'b0; sym_valid = 1'b0;
    check("wr_accept_old_err", {31'b0, err_unmapped}, 32'd1);
    check("wr_accept_no_bit", {31'b0, bit_valid}, 32'd0);
    run_sym(8'h55, 16'h0, 5'd0, 1'b0, 1'b0, bits, n, e1, br);
    check("new_55_bits", bits, 32'b1110);
    check("new_55_count", n, 4);

    run_sym(8'h0B, 16'h0, 5'd0, 1'b0, 1'b1, bits, n, e1, br);
    check("flush_acc_bits", bits, 32'b10);
    do_flush(1'b0, pads, wc, ones);
    check("flush_acc_pads", pads, 2);
    check("flush_acc_done", {31'b0, (wc >= 0)}, 32'd1);

    sym_in = 8'h0C; sym_valid = 1'b1; bit_ready = 1'b1;
    tick();
    sym_valid = 1'b0;
    tick();
    check("start_pre_valid", {31'b0, bit_valid}, 32'd1);
    start = 1'b1; bit_ready = 1'b0;
    #1 check("start_ready_low", {31'b0, sym_ready}, 32'd0);
    tick();
    start = 1'b0; bit_ready = 1'b1;
    check("start_drop_valid", {31'b0, bit_valid}, 32'd0);
    check("start_no_err", {31'b0, err_unmapped}, 32'd0);
    tick();
    check("start_stay_idle", {31'b0, bit_valid}, 32'd0);
    run_sym(8'h0A, 16'h0, 5'd0, 1'b0, 1'b0, bits, n, e1, br);
    check("start_tbl_kept_count", n, 1);
    check("start_tbl_kept_err", {31'b0, e1}, 32'd0);
    do_flush(1'b1, pads, wc, ones);
    check("start_cnt_cleared_pads", pads, 7);

    sym_in = 8'h0C; sym_valid = 1'b1;
    tick();
    sym_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1 check("async_rst_valid", {31'b0, bit_valid}, 32'd0);
    check("async_rst_ready", {31'b0, sym_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_sym(8'h0A, 16'h0, 5'd0, 1'b0, 1'b0, bits, n, e1, br);
    check("rst_tbl_cleared_err", {31'b0, e1}, 32'd1);
    check("rst_tbl_cleared_bits", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_huffman_encoder.md
Name: jpeg_huffman_encoder

Overview:
Bit-serial canonical Huffman encoder. It is the transmit-side counterpart of jpeg_huffman_decoder. Accepts 8-bit symbols plus optional raw magnitude bits, looks up code and length in an internal 256-entry table, and emits the bits MSB-first, one per handshake. Provides JPEG end-of-segment padding: flush fills with 1s to the next byte boundary.

Parameters:
CODE_W, 16, max Huffman code width in bits
LEN_W, 5, width of code-length field (lengths 0..16)
EXTRA_W, 16, max raw extra bits appended after the code

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  synchronous datapath clear (table untouched)
enable  in  1  allows new symbol acceptance
tbl_wr_en  in  1  table write strobe
tbl_wr_sym  in  8  table entry index
tbl_wr_code  in  CODE_W  code, right-aligned
tbl_wr_len  in  LEN_W  code length; 0 = unmapped
sym_in  in  8  symbol to encode
extra_in  in  EXTRA_W  raw bits, right-aligned
extra_len  in  5  number of extra bits (0..EXTRA_W)
sym_valid  in  1  symbol present
sym_ready  out  1  symbol accepted when valid & ready
flush  in  1  request byte-align padding (pulse)
bit_out  out  1  serial bit
bit_valid  out  1  bit_out valid
bit_ready  in  1  downstream accepts bit
flush_done  out  1  one-cycle pulse; padding complete
err_unmapped  out  1  one-cycle pulse; symbol had len 0

Behaviour:
- Reset (rst_n=0, async): state IDLE, bit_valid=0, bit_out=0, flush_done=0, err_unmapped=0, bit_cnt=0, flush_pend=0, all table lengths=0. sym_ready=0 while rst_n=0.
- Table write: on clk when tbl_wr_en=1, entry[tbl_wr_sym] <= {code,len}. Allowed in any state. A write in the same cycle as a symbol accept of the same index: accept latches the OLD entry. A symbol in flight keeps its latched code.
- sym_ready = (state==IDLE) & enable & ~flush_pend & ~start (combinational).
- States: IDLE, CODE, EXTRA, PAD.
- IDLE, accept with len>0: latch code/len/extra/extra_len and go to CODE. bit_valid=1 next cycle with bit_out=code[len-1]. Accept-to-first-bit latency is 1 cycle.
- IDLE, accept with len=0: err_unmapped=1 next cycle. Symbol dropped, no bits, remain IDLE.
- CODE: each bit_valid&bit_ready advances to the next lower code bit. After the bit at index 0 is taken, go to EXTRA if extra_len>0, else to IDLE with bit_valid=0. There is no gap between CODE and EXTRA bits.
- EXTRA: emits extra[extra_len-1] down to extra[0], then IDLE.
- One bubble cycle per symbol (IDLE). With bit_ready held at 1, a symbol of L total bits occupies L+1 cycles.
- bit_out and bit_valid are registered. While bit_valid=1 and bit_ready=0, bit_out holds stable.
- bit_cnt (3 bits) increments mod 8 on every bit handshake, including pad bits.
- flush: sets flush_pend in any state. In IDLE with flush_pend: if bit_cnt==0, pulse flush_done next cycle and clear flush_pend. Otherwise enter PAD and emit bit 1 until bit_cnt wraps to 0, then pulse flush_done, clear flush_pend, and return to IDLE.
- flush simultaneous with a symbol accept: the symbol is accepted first; the flush is serviced after it.
- start: synchronous. Returns to IDLE, clears bit_valid, bit_cnt and flush_pend, and drops any in-flight symbol without an error. Table is kept. start takes priority over tbl_wr_en? No: a table write in the same cycle still occurs.
- enable=0 blocks new accepts only. In-flight symbol and padding complete normally.
- extra_len > EXTRA_W: clamped to EXTRA_W.

Test Plan:
1. Load table 0x0A='0'/1, 0x0B='10'/2, 0x0C='110'/3; bit_ready=1; send 0x0A,0x0B,0x0C -> serial 0,1,0,1,1,0; bit_cnt=6; no err.
2. Send 0x0B with extra_in=3'b101, extra_len=3 -> bits 1,0,1,0,1 contiguous; sym_ready low for 5 cycles plus 1 bubble.
3. Repeat scenario 1 with bit_ready toggling 1,0,0,1,... -> same bit sequence; bit_out stable whenever bit_valid&~bit_ready.
4. After 6 bits, pulse flush -> pad bits 1,1, then flush_done pulse, bit_cnt=0. Pulse flush again -> flush_done next cycle with no bits.
5. Send unmapped 0x55 -> err_unmapped pulse 1 cycle, no bit_valid, sym_ready high again next cycle. Then write 0x55='1110'/4 while accepting 0x55 -> err (old entry); resend -> 1,1,1,0.
6. Assert rst_n=0 mid-0x0C (after 1 bit) -> bit_valid=0 immediately, table cleared; after reset, 0x0A -> err_unmapped. Separately, start mid-symbol -> remaining bits dropped and table intact.
